// File: rtl/audio_rom_streamer_pkg.sv
// Shared types for the audio ROM streamer: sample format and streamer FSM states.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    READ,
    CAPT,
    DONE
  } stream_state_e;

endpackage

// File: rtl/audio_rom_streamer_if.sv
// ROM read port and sample output stream of the audio ROM streamer.
// Handshake: a sample transfers on a clk edge where sample_valid && sample_ready;
// sample_data/sample_valid hold until that transfer, sample_ready may change freely.
interface audio_rom_streamer_if;
  import audio_pkg::*;

  logic [31:0] rom_addr;
  logic [15:0] rom_rd;
  sample_t     sample_data;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output rom_addr,
    input  rom_rd,
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  rom_addr,
    output rom_rd,
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/audio_rom_streamer_sample_fifo.sv
// Synchronous sample FIFO with flush and a registered head output.
// Push and pop may coincide at any occupancy, including full and empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type data_t = sample_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  push,
  input  data_t push_data,
  input  logic  pop,
  output data_t head,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  data_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_next    = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // The head register must see a same-cycle push when that entry becomes the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        head <= (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/audio_rom_streamer.sv
// Paces reads of the audio sample ROM at the sample rate, absorbs its one-cycle
// read latency and streams samples out through a small FIFO.
module audio_rom_streamer
  import audio_pkg::*;
#(
  parameter int NUM_SAMPLES = 64000,
  parameter int CLK_DIV     = 3125,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output stream_state_e         state_dbg,
  audio_rom_streamer_if.master  bus
);

  localparam int IDX_W = $clog2(NUM_SAMPLES);
  localparam int CNT_W = $clog2(CLK_DIV);

  stream_state_e    state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             last;
  logic             fifo_push;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;

  function automatic logic [31:0] addr_of(input logic [IDX_W-1:0] i);
    return 32'({i, 2'b00});
  endfunction

  assign tick       = busy && (tick_cnt == CNT_W'(CLK_DIV - 1));
  assign last       = (idx == IDX_W'(NUM_SAMPLES - 1));
  assign idx_inc    = last ? '0 : idx + 1'b1;
  assign fifo_flush = start || stop;
  // An abort in CAPT drops the in-flight ROM word.
  assign fifo_push  = (state == CAPT) && !fifo_flush;
  assign state_dbg  = state;
  assign bus.sample_valid = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (start || stop || !busy || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      bus.rom_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else if (stop) begin
      state        <= IDLE;
      idx          <= '0;
      bus.rom_addr <= '0;
      busy         <= 1'b0;
    end else if (start) begin
      state        <= WAIT_TICK;
      idx          <= '0;
      bus.rom_addr <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        WAIT_TICK: begin
          // A full FIFO holds the current index so the stream slips rather than skips.
          if (tick) begin
            if (fifo_full) begin
              overrun <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          if (last && !loop_en) begin
            state        <= DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            idx          <= '0;
            bus.rom_addr <= '0;
          end else begin
            state        <= WAIT_TICK;
            idx          <= idx_inc;
            bus.rom_addr <= addr_of(idx_inc);
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (sample_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (sample_t'(bus.rom_rd)),
    .pop       (bus.sample_ready),
    .head      (bus.sample_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_audio_rom_streamer.sv
// Self-checking bench for audio_rom_streamer with a small ROM model and scoreboards
// for the sample stream and the ROM address sequence.
module tb_audio_rom_streamer;
  import audio_pkg::*;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int FD  = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic          busy;
  logic          done;
  logic          overrun;
  stream_state_e state_dbg;

  audio_rom_streamer_if bus();

  audio_rom_streamer #(
    .NUM_SAMPLES (N),
    .CLK_DIV     (DIV),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word k holds 16'h1000 + k, one-cycle read latency
  always @(posedge clk) bus.rom_rd <= 16'h1000 + 16'(bus.rom_addr[31:2]);

  int          checks = 0;
  int          errors = 0;
  logic        sb_en  = 1'b1;
  logic [15:0] exp_q[$];
  logic [31:0] addr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic expect_seq(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(16'h1000 + 16'(i % N));
      addr_q.push_back(32'((i % N) * 4));
    end
  endtask

  task automatic wait_done_and_drain(input string tag);
    for (int i = 0; i < 400 && !done; i++) step(1);
    check({tag, "_done"}, 32'(done), 1);
    for (int i = 0; i < 50 && (bus.sample_valid || exp_q.size() != 0); i++) step(1);
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
    check({tag, "_addr_q"}, 32'(addr_q.size()), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rom_addr"}, bus.rom_addr, 0);
  endtask

  // scoreboard monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && state_dbg == READ && addr_q.size() != 0) begin
      check("rom_addr_seq", bus.rom_addr, addr_q.pop_front());
    end
    if (sb_en && bus.sample_valid && bus.sample_ready) begin
      check("sample_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sample", 32'(16'(bus.sample_data)), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    bus.sample_ready = 1'b1;
    step(2);

    // 1: reset values, start ignored while in reset
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_valid", 32'(bus.sample_valid), 0);
    check("rst_data", 32'(16'(bus.sample_data)), 0);
    pulse_start();
    step(DIV * 3);
    check("rst_start_busy", 32'(busy), 0);
    check("rst_start_state", 32'(state_dbg), 32'(IDLE));
    check("rst_start_valid", 32'(bus.sample_valid), 0);
    rst = 1'b0;
    step(2);

    // 2: one-shot playback
    expect_seq(N);
    pulse_start();
    check("start_busy", 32'(busy), 1);
    wait_done_and_drain("oneshot");
    check("oneshot_state", 32'(state_dbg), 32'(DONE));

    // 3: loop playback wraps to sample 0
    loop_en = 1'b1;
    expect_seq(N + 2);
    pulse_start();
    check("loop_done_cleared", 32'(done), 0);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step(1);
    sb_en = 1'b0;
    check("loop_drained", 32'(exp_q.size()), 0);
    check("loop_done", 32'(done), 0);
    check("loop_busy", 32'(busy), 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("loop_stop_valid", 32'(bus.sample_valid), 0);
    check("loop_stop_busy", 32'(busy), 0);
    addr_q.delete();
    exp_q.delete();
    step(2);
    sb_en = 1'b1;

    // 4: backpressure fills the FIFO, next tick overruns without skipping
    loop_en = 1'b0;
    bus.sample_ready = 1'b0;
    expect_seq(N);
    pulse_start();
    for (int i = 0; i < 200 && !overrun; i++) step(1);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_rom_addr", bus.rom_addr, 32'h10);
    check("ovr_valid", 32'(bus.sample_valid), 1);
    step(DIV * 3 + $urandom_range(0, 3));
    check("ovr_hold_addr", bus.rom_addr, 32'h10);
    check("ovr_hold_state", 32'(state_dbg), 32'(WAIT_TICK));
    bus.sample_ready = 1'b1;
    wait_done_and_drain("ovr");
    check("ovr_sticky", 32'(overrun), 1);

    // 5: stop in CAPT drops the in-flight sample
    addr_q.push_back(32'h0);
    pulse_start();
    check("start_clears_ovr", 32'(overrun), 0);
    for (int i = 0; i < 50 && state_dbg != CAPT; i++) step(1);
    check("reach_capt", 32'(state_dbg), 32'(CAPT));
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_valid", 32'(bus.sample_valid), 0);
    check("stop_rom_addr", bus.rom_addr, 0);
    check("stop_busy", 32'(busy), 0);
    step(DIV * 2);
    check("stop_no_push", 32'(bus.sample_valid), 0);
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    check("startstop_state", 32'(state_dbg), 32'(IDLE));
    check("startstop_busy", 32'(busy), 0);
    step(DIV * 3);
    check("startstop_no_push", 32'(bus.sample_valid), 0);
    check("stop_addr_q", 32'(addr_q.size()), 0);

    // 6: async reset mid-READ, then replay from sample 0
    pulse_start();
    for (int i = 0; i < 50 && state_dbg != READ; i++) step(1);
    check("reach_read", 32'(state_dbg), 32'(READ));
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state_dbg), 32'(IDLE));
    check("arst_busy", 32'(busy), 0);
    check("arst_rom_addr", bus.rom_addr, 0);
    check("arst_valid", 32'(bus.sample_valid), 0);
    step(2);
    rst = 1'b0;
    step(1);
    check("arst_no_push", 32'(bus.sample_valid), 0);
    expect_seq(N);
    pulse_start();
    wait_done_and_drain("replay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
